// File: rtl/stim_pkg.sv
// Shared types and layout helpers for the stimulus replay player.
// Field positions derive from DATA_W/HOLD_W so the table and the player agree on the entry layout.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int entry_w(input int data_w, input int hold_w);
        return 1 + hold_w + data_w;
    endfunction

    function automatic int hold_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int obs_bit(input int data_w, input int hold_w);
        return data_w + hold_w;
    endfunction

endpackage

// File: rtl/stim_replay_if.sv
// Valid/ready stimulus bus between the replay player (master) and the DUT input pins (slave).
interface stim_replay_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              stim_valid;
    logic              stim_ready;
    logic [DATA_W-1:0] stim_data;
    logic              stim_obs;
    logic [ADDR_W-1:0] stim_pc;

    modport master (output stim_valid, stim_data, stim_obs, stim_pc, input stim_ready);
    modport slave  (input stim_valid, stim_data, stim_obs, stim_pc, output stim_ready);
endinterface

// File: rtl/stim_table.sv
// DEPTH x ENTRY_W entry store: synchronous write, asynchronous read, contents never reset.
// Writes beyond DEPTH-1 (non power-of-two depths) are dropped.
module stim_table import stim_pkg::*; #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 13,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/stim_replay.sv
// Replays table entries {obs, hold, data} onto a valid/ready bus, each entry for hold+1 transfers.
// Optional wrap-around replay and loop counter when STIM_LOOP_EN is defined.
module stim_replay import stim_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 4,
    localparam int ADDR_W  = addr_w(DEPTH),
    localparam int ENTRY_W = entry_w(DATA_W, HOLD_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_en,
    stim_replay_if.master      stim,
    output logic               busy,
    output logic               done
`ifdef STIM_LOOP_EN
    ,
    output logic [7:0]         loop_cnt
`endif
);

    localparam int HOLD_LSB = hold_lsb(DATA_W);
    localparam int OBS_BIT  = obs_bit(DATA_W, HOLD_W);

    state_e              r_state, w_state;
    logic [ADDR_W-1:0]   r_pc, w_pc, r_last, w_last;
    logic [HOLD_W-1:0]   r_hold, w_hold;
    logic [DATA_W-1:0]   r_data, w_data;
    logic                r_valid, w_valid, r_obs, w_obs, r_done, w_done, r_busy;
    logic                w_xfer, w_wrap, w_load;
    logic [ADDR_W-1:0]   w_nxt_pc, w_rd_addr, w_last_clamped;
    logic [ENTRY_W-1:0]  w_rd_data;
`ifdef STIM_LOOP_EN
    logic [7:0]          r_loop_cnt;
    logic                w_clr_loop, w_inc_loop;
    assign w_wrap = loop_en;
`else
    assign w_wrap = loop_en & 1'b0;
`endif

    stim_table #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W)) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    assign w_last_clamped = (int'(last_addr) >= DEPTH) ? ADDR_W'(DEPTH - 1) : last_addr;
    assign w_xfer         = r_valid & stim.stim_ready;
    assign w_nxt_pc       = (r_pc == r_last) ? '0 : r_pc + 1'b1;
    // Outside RUN the only possible load is entry 0 on start.
    assign w_rd_addr      = (r_state == ST_RUN) ? w_nxt_pc : '0;

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_last  = r_last;
        w_hold  = r_hold;
        w_data  = r_data;
        w_obs   = r_obs;
        w_valid = r_valid;
        w_done  = r_done;
        w_load  = 1'b0;
`ifdef STIM_LOOP_EN
        w_clr_loop = 1'b0;
        w_inc_loop = 1'b0;
`endif
        if (abort) begin
            w_state = ST_IDLE;
            w_valid = 1'b0;
            w_done  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state = ST_RUN;
                        w_load  = 1'b1;
                        w_last  = w_last_clamped;
                        w_done  = 1'b0;
`ifdef STIM_LOOP_EN
                        w_clr_loop = 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (r_hold != '0) begin
                            w_hold = r_hold - 1'b1;
                        end else if ((r_pc != r_last) || w_wrap) begin
                            w_load = 1'b1;
`ifdef STIM_LOOP_EN
                            w_inc_loop = (r_pc == r_last);
`endif
                        end else begin
                            w_state = ST_DONE;
                            w_valid = 1'b0;
                            w_done  = 1'b1;
                        end
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
        if (w_load) begin
            w_pc    = w_rd_addr;
            w_hold  = w_rd_data[HOLD_LSB +: HOLD_W];
            w_data  = w_rd_data[DATA_W-1:0];
            w_obs   = w_rd_data[OBS_BIT];
            w_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_last  <= '0;
            r_hold  <= '0;
            r_data  <= '0;
            r_obs   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_last  <= w_last;
            r_hold  <= w_hold;
            r_data  <= w_data;
            r_obs   <= w_obs;
            r_valid <= w_valid;
            r_done  <= w_done;
            r_busy  <= (w_state == ST_RUN);
        end
    end

`ifdef STIM_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst || (!abort && w_clr_loop)) begin
            r_loop_cnt <= '0;
        end else if (!abort && w_inc_loop && (r_loop_cnt != 8'hFF)) begin
            r_loop_cnt <= r_loop_cnt + 8'd1;
        end
    end
    assign loop_cnt = r_loop_cnt;
`endif

    assign stim.stim_valid = r_valid;
    assign stim.stim_data  = r_data;
    assign stim.stim_obs   = r_obs;
    assign stim.stim_pc    = r_pc;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_stim_replay.sv
// Scenario bench for stim_replay (DEPTH=10 so the last_addr clamp is reachable); a negedge
// monitor pops the expected-transfer queue on every valid&ready cycle.
module tb_stim_replay;
    typedef struct packed {
        logic [3:0] pc;
        logic       obs;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, start, abort, loop_en;
    logic [3:0]  wr_addr, last_addr;
    logic [12:0] wr_data;
    logic        busy, done;
`ifdef STIM_LOOP_EN
    logic [7:0]  loop_cnt;
`endif
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    stim_replay_if #(.DATA_W(8), .ADDR_W(4)) sif ();

    stim_replay #(.DATA_W(8), .DEPTH(10), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .last_addr (last_addr),
        .start     (start),
        .abort     (abort),
        .loop_en   (loop_en),
        .stim      (sif),
        .busy      (busy),
        .done      (done)
`ifdef STIM_LOOP_EN
        ,
        .loop_cnt  (loop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && sif.stim_valid && sif.stim_ready) begin
            exp_t got, want;
            got = '{sif.stim_pc, sif.stim_obs, sif.stim_data};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got pc=%0d obs=%0b data=%h, required none", got.pc, got.obs, got.data);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL xfer: got pc=%0d obs=%0b data=%h, required pc=%0d obs=%0b data=%h",
                             got.pc, got.obs, got.data, want.pc, want.obs, want.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic o, input int h, input int d);
        wr_addr = 4'(a);
        wr_data = {o, 4'(h), 8'(d)};
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push(input int pc, input logic o, input int d);
        sb.push_back('{4'(pc), o, 8'(d)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        wr_addr = '0; wr_data = '0; last_addr = '0; sif.stim_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({sif.stim_valid, sif.stim_obs, sif.stim_data, sif.stim_pc, busy, done} !== 16'h0) begin
            errors++;
            $display("FAIL reset: got valid=%b obs=%b data=%h pc=%0d busy=%b done=%b, required all 0",
                     sif.stim_valid, sif.stim_obs, sif.stim_data, sif.stim_pc, busy, done);
        end
    endtask

    task automatic test_basic();
        int cnt = 0;
        write_entry(0, 1'b1, 0, 8'h11);
        write_entry(1, 1'b0, 0, 8'h22);
        write_entry(2, 1'b1, 0, 8'h33);
        last_addr = 4'd2;
        sif.stim_ready = 1'b1;
        push(0, 1'b1, 8'h11); push(1, 1'b0, 8'h22); push(2, 1'b1, 8'h33);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (sif.stim_valid) cnt++;
            tick();
        end
        checks++;
        if (cnt !== 3) begin errors++; $display("FAIL basic_valid_cycles: got %0d, required 3", cnt); end
        checks++;
        if ({done, sif.stim_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL basic_end: got done/valid/busy=%b%b%b, required 100", done, sif.stim_valid, busy);
        end
        checks++;
        if (sif.stim_pc !== 4'd2 || sif.stim_data !== 8'h33) begin
            errors++; $display("FAIL basic_hold_last: got pc=%0d data=%h, required pc=2 data=33", sif.stim_pc, sif.stim_data);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL basic_sb: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_restart();
        push(0, 1'b1, 8'h11); push(1, 1'b0, 8'h22); push(2, 1'b1, 8'h33);
        pulse_start();
        checks++;
        if ({done, sif.stim_valid, busy} !== 3'b011 || sif.stim_pc !== 4'd0 || sif.stim_data !== 8'h11) begin
            errors++;
            $display("FAIL restart: got done=%b valid=%b busy=%b pc=%0d data=%h, required 0 1 1 0 11",
                     done, sif.stim_valid, busy, sif.stim_pc, sif.stim_data);
        end
        repeat (8) tick();
        checks++;
        if (done !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL restart_end: got done=%b left=%0d, required 1 0", done, sb.size());
        end
    endtask

    task automatic test_midrun_write();
        push(0, 1'b1, 8'h11); push(1, 1'b0, 8'h22); push(2, 1'b1, 8'h33);
        pulse_start();
        tick();
        sif.stim_ready = 1'b0;
        write_entry(1, 1'b0, 0, 8'hEE);
        checks++;
        if (sif.stim_pc !== 4'd1 || sif.stim_data !== 8'h22) begin
            errors++; $display("FAIL midwrite_old: got pc=%0d data=%h, required pc=1 data=22", sif.stim_pc, sif.stim_data);
        end
        sif.stim_ready = 1'b1;
        repeat (8) tick();
        push(0, 1'b1, 8'h11); push(1, 1'b0, 8'hEE); push(2, 1'b1, 8'h33);
        pulse_start();
        repeat (8) tick();
        checks++;
        if (done !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL midwrite_end: got done=%b left=%0d, required 1 0", done, sb.size());
        end
    endtask

    task automatic test_hold_stall();
        int cnt0 = 0;
        int cnt_all = 0;
        write_entry(0, 1'b0, 2, 8'hA5);
        write_entry(1, 1'b1, 0, 8'h5A);
        last_addr = 4'd1;
        push(0, 1'b0, 8'hA5); push(0, 1'b0, 8'hA5); push(0, 1'b0, 8'hA5); push(1, 1'b1, 8'h5A);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (sif.stim_valid) cnt_all++;
            if (sif.stim_valid && sif.stim_pc == 4'd0) cnt0++;
            if (i == 4) begin
                checks++;
                if (sif.stim_valid !== 1'b1 || sif.stim_pc !== 4'd0 || sif.stim_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL stall_frozen: got valid=%b pc=%0d data=%h, required 1 0 a5",
                             sif.stim_valid, sif.stim_pc, sif.stim_data);
                end
            end
            if (i == 1) sif.stim_ready = 1'b0;
            if (i == 5) sif.stim_ready = 1'b1;
            tick();
        end
        checks++;
        if (cnt0 !== 7 || cnt_all !== 8) begin
            errors++; $display("FAIL hold_cycles: got entry0=%0d total=%0d, required 7 8", cnt0, cnt_all);
        end
        checks++;
        if (done !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL hold_end: got done=%b left=%0d, required 1 0", done, sb.size());
        end
    endtask

    task automatic test_abort();
        write_entry(0, 1'b0, 0, 8'h01);
        write_entry(1, 1'b0, 0, 8'h02);
        write_entry(2, 1'b0, 0, 8'h03);
        last_addr = 4'd2;
        push(0, 1'b0, 8'h01); push(1, 1'b0, 8'h02);
        pulse_start();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({sif.stim_valid, done, busy} !== 3'b000 || sif.stim_pc !== 4'd1) begin
            errors++;
            $display("FAIL abort: got valid=%b done=%b busy=%b pc=%0d, required 0 0 0 pc=1",
                     sif.stim_valid, done, busy, sif.stim_pc);
        end
        repeat (3) tick();
        checks++;
        if (sif.stim_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL abort_idle: got valid=%b left=%0d, required 0 0", sif.stim_valid, sb.size());
        end
    endtask

    task automatic test_clamp();
        int cnt = 0;
        for (int i = 0; i < 10; i++) begin
            write_entry(i, 1'(i), 0, 8'h40 + i);
            push(i, 1'(i), 8'h40 + i);
        end
        last_addr = 4'd12;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (sif.stim_valid) cnt++;
            tick();
        end
        checks++;
        if (cnt !== 10 || done !== 1'b1 || sif.stim_pc !== 4'd9) begin
            errors++; $display("FAIL clamp: got cycles=%0d done=%b pc=%0d, required 10 1 9", cnt, done, sif.stim_pc);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL clamp_sb: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_loop();
        write_entry(0, 1'b0, 0, 8'h60);
        write_entry(1, 1'b1, 0, 8'h61);
        last_addr = 4'd1;
        loop_en = 1'b1;
`ifdef STIM_LOOP_EN
        for (int i = 0; i < 7; i++) push(i % 2, 1'(i % 2), 8'h60 + (i % 2));
        pulse_start();
        repeat (7) tick();
        sif.stim_ready = 1'b0;
        checks++;
        if (loop_cnt !== 8'd3 || sif.stim_pc !== 4'd1 || sif.stim_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop: got loop_cnt=%0d pc=%0d valid=%b busy=%b, required 3 1 1 1",
                     loop_cnt, sif.stim_pc, sif.stim_valid, busy);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL loop_sb: got %0d left, required 0", sb.size()); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sif.stim_ready = 1'b1;
`else
        begin
            int cnt = 0;
            push(0, 1'b0, 8'h60); push(1, 1'b1, 8'h61);
            pulse_start();
            for (int i = 0; i < 10; i++) begin
                if (sif.stim_valid) cnt++;
                tick();
            end
            checks++;
            if (cnt !== 2 || done !== 1'b1 || sb.size() != 0) begin
                errors++; $display("FAIL noloop: got cycles=%0d done=%b left=%0d, required 2 1 0", cnt, done, sb.size());
            end
        end
`endif
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_midrun_write();
        test_hold_stall();
        test_abort();
        test_clamp();
        test_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stim_replay.md
# stim_replay

Synthesizable, parametrised stimulus sequencer that replays a loaded table of `{obs, hold, data}` entries onto a DUT input bus, one entry per accepted transfer. It replaces the fixed 9-bit, free-running program counter of our generated conquest testbench with a controllable player. The player has start/abort control, per-entry hold counts, valid/ready back-pressure and optional looping. It sits between the bench or host loader and the DUT's `in`/`__obs` pins.

## Interface
- `DATA_W`, 8: payload width driven to the DUT.
- `DEPTH`, 16: number of table entries, ≥2. `ADDR_W = $clog2(DEPTH)`.
- `HOLD_W`, 4: hold-count field width. An entry is presented for `hold+1` transfers.
- `ENTRY_W` (derived): `1 + HOLD_W + DATA_W`. Layout is `[ENTRY_W-1]` obs, then `[DATA_W+HOLD_W-1:DATA_W]` hold, then `[DATA_W-1:0]` data.

Ports:
- `clk` in 1: the only clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in ADDR_W: table write address.
- `wr_data` in ENTRY_W: table write entry.
- `last_addr` in ADDR_W: index of the final entry; sampled on start; values ≥DEPTH clamp to DEPTH-1.
- `start` in 1: begin replay from entry 0.
- `abort` in 1: stop immediately and return to IDLE.
- `loop_en` in 1: wrap to entry 0 after the last entry. Ignored unless `STIM_LOOP_EN` is defined.
- `stim_ready` in 1: consumer accepts the current entry.
- `stim_valid` out 1: an entry is presented.
- `stim_data` out DATA_W: presented payload.
- `stim_obs` out 1: presented observe flag.
- `stim_pc` out ADDR_W: index of the presented entry.
- `busy` out 1: high in RUN.
- `done` out 1: sticky completion flag.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** state IDLE. `stim_valid`, `stim_data`, `stim_obs`, `stim_pc`, `busy`, `done` and the hold counter all go to 0. Table contents are not reset.
- **Writes:** accepted in any state, one per cycle.
  - A write to the entry currently presented does not alter the registered outputs.
  - That write is seen the next time the entry is loaded.
- **Starting:** `start` in IDLE or DONE moves to RUN.
  - Entry 0 is loaded into the outputs, `hold_cnt` is set to entry 0's hold, and `last_addr` is latched.
  - `done` clears.
  - `start` in RUN is ignored.
- **Transfer:** a transfer is `stim_valid & stim_ready`.
  - With `hold_cnt > 0`, a transfer decrements `hold_cnt` and the outputs are unchanged.
  - With `hold_cnt == 0` and pc < last, a transfer loads entry pc+1.
- **Final transfer of the last entry:**
  - If looping is enabled, load entry 0 and stay in RUN.
  - Otherwise go to DONE: `stim_valid` goes to 0, `done` goes to 1, and `stim_data`/`stim_obs`/`stim_pc` hold their last values.
- **Abort:** `abort` in any state goes to IDLE next cycle.
  - `stim_valid`, `busy` and `done` go to 0.
  - `abort` has priority over `start` and over a transfer in the same cycle.
- **Stall:** while `stim_ready` is low, the outputs and `hold_cnt` are frozen.
- **Entry count:** `last_addr` = 0 gives a single-entry table. That entry is replayed `hold+1` times, then the block goes to DONE, or repeats if looping.

## Timing
- `start` sampled at edge N gives `stim_valid` = 1 with entry 0 after edge N.
- All outputs are registered. The table read is combinational from the array into the output registers.
- With `stim_ready` held at 1, throughput is one transfer per cycle.
  - A table with every hold = 0 and last = L drives L+1 consecutive cycles of valid.
  - `stim_valid` falls after the edge of the last transfer.
- Entry pc+1 appears the cycle after the edge at which entry pc made its final transfer. There are no bubbles.
- `busy` equals state==RUN, registered.

## Configuration
- **`STIM_LOOP_EN` defined:** `loop_en` is honoured at the end of each pass.
  - An extra output `loop_cnt` (out, 8 bits, reset 0) increments on each wrap. It saturates at 255 and clears on `start`.
- **Not defined:** `loop_en` is ignored, `loop_cnt` is absent, and every run ends in DONE.

## Structure
- **Package `stim_pkg`:** the state enum (IDLE/RUN/DONE), the entry field-position functions or constants derived from `DATA_W`/`HOLD_W`, and the `ADDR_W` helper.
- **Sub-module `stim_table`:** the DEPTH×ENTRY_W register array with a synchronous write port and an asynchronous read port. The top level holds the FSM, pc, hold counter and output registers.

## Test plan
- **Basic replay:** load data 0x11,0x22,0x33, hold 0, obs 1/0/1; last_addr=2; start; ready=1. Expect valid for exactly 3 cycles with data 11,22,33, obs 1,0,1, then `done`=1 and valid=0.
- **Hold and stall:**
  - Entry 0 has hold=2 and data 0xA5. Expect 0xA5 presented for 3 transfers.
  - Drop ready for 4 cycles mid-hold. Expect outputs and remaining count frozen, and total valid cycles = 3 + 4.
- **Abort:** abort in the same cycle as a transfer at pc=1. Expect IDLE next cycle, valid=0, done=0, and no advance to pc=2.
- **Restart and clamp:**
  - Start from DONE. Expect entry 0 again and done cleared.
  - `last_addr` ≥ DEPTH (possible only when DEPTH is not a power of two, e.g. DEPTH=10, last_addr=12). Expect replay of 10 entries.
- **Mid-run write:** write entry 1 = 0xEE while entry 1 is presented. Expect the old value to persist; a second pass shows 0xEE.
- **Looping (`STIM_LOOP_EN`, `loop_en`=1):**
  - Table of 2 entries run for 7 transfers. Expect pc sequence 0,1,0,1,0,1,0 and `loop_cnt`=3.
  - Without the macro, the same stimulus ends in DONE after 2 transfers.
